// File: rtl/mem_stage_lsu.sv
// Memory stage: passes ALU ops to writeback in 1 cycle; loads/stores run a REQ/WAIT_R handshake on dmem.
// Memory ops stall upstream until grant (stores) or rvalid (loads); misaligned accesses are flagged, not issued.
module mem_stage_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_imm_i,
  input  logic [31:0] ex_alu_result_i,
  input  logic [31:0] ex_store_data_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_regwrite_i,
  input  logic [1:0]  ex_sel_to_reg_i,
  input  logic        ex_mem_read_i,
  input  logic        ex_mem_write_i,
  input  logic        ex_unsigned_i,
  input  logic [1:0]  ex_size_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_regwrite_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_pc_o,
  output logic [31:0] wb_imm_o,
  output logic [31:0] wb_alu_result_o,
  output logic [1:0]  wb_sel_to_reg_o,
  output logic [31:0] wb_load_data_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;
  state_t state, state_nxt;

  logic [31:0] addr_q, wdata_q, pc_q, imm_q;
  logic [3:0]  be_q;
  logic [1:0]  size_q, sel_q;
  logic [4:0]  rd_q;
  logic        unsigned_q, we_q, regwrite_q;

  logic [1:0]  ofs;
  logic        is_mem, misaligned, accept, regwrite_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in, rshift, load_data;

  assign ofs         = ex_alu_result_i[1:0];
  assign is_mem      = ex_valid_i & (ex_mem_read_i | ex_mem_write_i);
  assign misaligned  = ((ex_size_i == 2'b01) & ofs[0]) | (ex_size_i[1] & (ofs != 2'b00));
  assign accept      = is_mem & ~misaligned;
  assign regwrite_in = ex_regwrite_i & ex_valid_i & (ex_rd_i != 5'd0);

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = ex_store_data_i;
    case (ex_size_i)
      2'b00: begin
        be_in    = 4'b0001 << ofs;
        wdata_in = {4{ex_store_data_i[7:0]}};
      end
      2'b01: begin
        be_in    = 4'b0011 << ofs;
        wdata_in = {2{ex_store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Returned word is shifted so the addressed byte lands in bit 0.
  always_comb begin
    rshift    = dmem_rdata_i >> {addr_q[1:0], 3'b000};
    load_data = rshift;
    case (size_q)
      2'b00:   load_data = unsigned_q ? {24'd0, rshift[7:0]}  : {{24{rshift[7]}}, rshift[7:0]};
      2'b01:   load_data = unsigned_q ? {16'd0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    stall_o    = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall_o   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = we_q;
        stall_o    = 1'b1;
        if (dmem_gnt_i) begin
          state_nxt = we_q ? IDLE : WAIT_R;
          stall_o   = ~we_q;
        end
      end
      WAIT_R: begin
        if (dmem_rvalid_i) state_nxt = IDLE;
        else               stall_o   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset must silence the handshake outputs even with live ex_* inputs.
    if (!rst_n) begin
      stall_o    = 1'b0;
      dmem_req_o = 1'b0;
      dmem_we_o  = 1'b0;
    end
  end

  assign dmem_addr_o  = {addr_q[31:2], 2'b00};
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0; wdata_q <= '0; pc_q <= '0; imm_q <= '0;
      be_q <= '0; size_q <= '0; sel_q <= '0; rd_q <= '0;
      unsigned_q <= 1'b0; we_q <= 1'b0; regwrite_q <= 1'b0;
      wb_regwrite_o <= 1'b0; wb_rd_o <= '0; wb_pc_o <= '0; wb_imm_o <= '0;
      wb_alu_result_o <= '0; wb_sel_to_reg_o <= '0; wb_load_data_o <= '0;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q        <= ex_alu_result_i;
            wdata_q       <= wdata_in;
            be_q          <= be_in;
            size_q        <= ex_size_i;
            unsigned_q    <= ex_unsigned_i;
            we_q          <= ex_mem_write_i;
            rd_q          <= ex_rd_i;
            regwrite_q    <= regwrite_in;
            pc_q          <= ex_pc_i;
            imm_q         <= ex_imm_i;
            sel_q         <= ex_sel_to_reg_i;
            wb_regwrite_o <= 1'b0;
          end else if (is_mem) begin
            misalign_o    <= 1'b1;
            wb_regwrite_o <= 1'b0;
          end else begin
            wb_regwrite_o   <= regwrite_in;
            wb_rd_o         <= ex_rd_i;
            wb_pc_o         <= ex_pc_i;
            wb_imm_o        <= ex_imm_i;
            wb_alu_result_o <= ex_alu_result_i;
            wb_sel_to_reg_o <= ex_sel_to_reg_i;
          end
        end
        REQ: begin
          if (dmem_gnt_i && we_q) begin
            wb_regwrite_o   <= 1'b0;
            wb_rd_o         <= rd_q;
            wb_pc_o         <= pc_q;
            wb_imm_o        <= imm_q;
            wb_alu_result_o <= addr_q;
            wb_sel_to_reg_o <= sel_q;
          end
        end
        WAIT_R: begin
          if (dmem_rvalid_i) begin
            wb_regwrite_o   <= regwrite_q;
            wb_rd_o         <= rd_q;
            wb_pc_o         <= pc_q;
            wb_imm_o        <= imm_q;
            wb_alu_result_o <= addr_q;
            wb_sel_to_reg_o <= sel_q;
            wb_load_data_o  <= load_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: ALU passthrough, loads, stores, misalignment and reset abort.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_regwrite, ex_mem_read, ex_mem_write, ex_unsigned;
  logic [31:0] ex_pc, ex_imm, ex_alu, ex_sdata;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_sel, ex_size;
  logic        stall, req, we, gnt, rvalid;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        wb_regwrite, misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_pc, wb_imm, wb_alu, wb_load;
  logic [1:0]  wb_sel;

  int tests = 0;
  int fails = 0;
  int nstall;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid), .ex_pc_i(ex_pc), .ex_imm_i(ex_imm),
    .ex_alu_result_i(ex_alu), .ex_store_data_i(ex_sdata),
    .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite), .ex_sel_to_reg_i(ex_sel),
    .ex_mem_read_i(ex_mem_read), .ex_mem_write_i(ex_mem_write),
    .ex_unsigned_i(ex_unsigned), .ex_size_i(ex_size),
    .stall_o(stall),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_be_o(be),
    .dmem_wdata_o(wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
    .wb_regwrite_o(wb_regwrite), .wb_rd_o(wb_rd), .wb_pc_o(wb_pc), .wb_imm_o(wb_imm),
    .wb_alu_result_o(wb_alu), .wb_sel_to_reg_o(wb_sel), .wb_load_data_o(wb_load),
    .misalign_o(misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_regwrite = 0; ex_mem_read = 0; ex_mem_write = 0; ex_unsigned = 0;
    ex_pc = 0; ex_imm = 0; ex_alu = 0; ex_sdata = 0; ex_rd = 0; ex_sel = 0; ex_size = 0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; gnt = 0; rvalid = 0; rdata = 0;
    clear_ex();
    edge_step(); edge_step();
    chk("rst_stall", stall, 0);
    chk("rst_req", req, 0);
    chk("rst_we", we, 0);
    chk("rst_wb_regwrite", wb_regwrite, 0);
    chk("rst_wb_alu", wb_alu, 0);
    chk("rst_misalign", misalign, 0);
    rst_n = 1;

    // ALU op
    ex_valid = 1; ex_regwrite = 1; ex_rd = 5; ex_alu = 32'h1234; ex_sel = 2'b01;
    ex_pc = 32'h40; ex_imm = 32'h7;
    #1 chk("alu_stall", stall, 0);
    chk("alu_req", req, 0);
    edge_step();
    chk("alu_wb_regwrite", wb_regwrite, 1);
    chk("alu_wb_rd", wb_rd, 5);
    chk("alu_wb_alu", wb_alu, 32'h1234);
    chk("alu_wb_sel", wb_sel, 1);
    chk("alu_wb_pc", wb_pc, 32'h40);
    chk("alu_wb_imm", wb_imm, 32'h7);

    // LB signed at 0x103: two cycles without grant, grant, then rvalid
    ex_rd = 7; ex_sel = 2'b10; ex_alu = 32'h103; ex_mem_read = 1; ex_size = 2'b00; ex_unsigned = 0;
    nstall = 0;
    #1 if (stall) nstall++;
    chk("lb_idle_req", req, 0);
    edge_step();
    chk("lb_bubble", wb_regwrite, 0);
    ex_alu = 32'hFFFF_FFFC;
    for (int i = 0; i < 3; i++) begin
      gnt = (i == 2); rvalid = (i == 2); rdata = 32'h1111_1111;
      #1 if (stall) nstall++;
      chk("lb_req", req, 1);
      chk("lb_addr", addr, 32'h100);
      chk("lb_we", we, 0);
      edge_step();
    end
    gnt = 0; rvalid = 1; rdata = 32'h80FF_FF00; ex_valid = 0; ex_mem_read = 0;
    #1 if (stall) nstall++;
    chk("lb_wait_req", req, 0);
    edge_step();
    rvalid = 0;
    chk("lb_stall_cycles", nstall, 4);
    chk("lb_load", wb_load, 32'hFFFF_FF80);
    chk("lb_wb_regwrite", wb_regwrite, 1);
    chk("lb_wb_rd", wb_rd, 7);
    chk("lb_wb_sel", wb_sel, 2);
    chk("lb_wb_alu", wb_alu, 32'h103);

    // SH at 0x22, grant immediately
    ex_valid = 1; ex_mem_write = 1; ex_size = 2'b01; ex_alu = 32'h22; ex_sdata = 32'h0000_ABCD;
    ex_rd = 3; ex_regwrite = 1; ex_sel = 2'b01;
    #1 chk("sh_idle_stall", stall, 1);
    edge_step();
    ex_valid = 0; ex_mem_write = 0; gnt = 1;
    #1 chk("sh_be", be, 4'b1100);
    chk("sh_wdata", wdata, 32'hABCD_ABCD);
    chk("sh_we", we, 1);
    chk("sh_addr", addr, 32'h20);
    chk("sh_gnt_stall", stall, 0);
    edge_step();
    gnt = 0;
    chk("sh_wb_regwrite", wb_regwrite, 0);
    chk("sh_wb_rd", wb_rd, 3);
    chk("sh_req_after", req, 0);

    // SB with both read and write set behaves as a store
    ex_valid = 1; ex_mem_write = 1; ex_mem_read = 1; ex_size = 2'b00; ex_alu = 32'h101;
    ex_sdata = 32'h1234_565A;
    edge_step();
    ex_valid = 0; ex_mem_write = 0; ex_mem_read = 0; gnt = 1;
    #1 chk("sb_be", be, 4'b0010);
    chk("sb_wdata", wdata, 32'h5A5A_5A5A);
    chk("sb_we", we, 1);
    chk("sb_stall", stall, 0);
    edge_step();
    gnt = 0;

    // ALU op then misaligned LW at 0x41
    ex_valid = 1; ex_regwrite = 1; ex_rd = 9; ex_alu = 32'h55; ex_sel = 2'b01;
    edge_step();
    chk("alu2_wb_regwrite", wb_regwrite, 1);
    ex_mem_read = 1; ex_size = 2'b10; ex_alu = 32'h41;
    #1 chk("lw_mis_stall", stall, 0);
    chk("lw_mis_req", req, 0);
    edge_step();
    chk("lw_mis_flag", misalign, 1);
    chk("lw_mis_regwrite", wb_regwrite, 0);
    chk("lw_mis_req_after", req, 0);
    ex_valid = 0; ex_mem_read = 0;
    edge_step();
    chk("lw_mis_pulse_end", misalign, 0);

    // LHU at 0x2
    ex_valid = 1; ex_mem_read = 1; ex_size = 2'b01; ex_unsigned = 1; ex_alu = 32'h2; ex_rd = 4;
    ex_regwrite = 1;
    edge_step();
    ex_valid = 0; ex_mem_read = 0; gnt = 1;
    #1 chk("lhu_req_stall", stall, 1);
    edge_step();
    gnt = 0; rvalid = 1; rdata = 32'h8001_0000;
    #1 chk("lhu_rvalid_stall", stall, 0);
    edge_step();
    rvalid = 0;
    chk("lhu_load", wb_load, 32'h0000_8001);
    chk("lhu_wb_regwrite", wb_regwrite, 1);
    ex_unsigned = 0;

    // Reset while in WAIT_R, late rvalid must be ignored
    ex_valid = 1; ex_mem_read = 1; ex_size = 2'b10; ex_alu = 32'h300; ex_rd = 6;
    edge_step();
    ex_valid = 0; ex_mem_read = 0; gnt = 1;
    edge_step();
    gnt = 0;
    #1 chk("wr_wait_stall", stall, 1);
    rst_n = 0;
    #1 chk("wr_rst_req", req, 0);
    chk("wr_rst_stall", stall, 0);
    chk("wr_rst_wb_regwrite", wb_regwrite, 0);
    #4 rst_n = 1;
    rvalid = 1; rdata = 32'hFFFF_FFFF;
    #1 chk("wr_late_stall", stall, 0);
    edge_step();
    rvalid = 0;
    chk("wr_late_regwrite", wb_regwrite, 0);
    chk("wr_late_load", wb_load, 0);

    // Reset while in REQ drops the request at once
    ex_valid = 1; ex_mem_read = 1; ex_size = 2'b10; ex_alu = 32'h400; ex_rd = 6;
    edge_step();
    ex_valid = 0; ex_mem_read = 0;
    #1 chk("rq_req", req, 1);
    rst_n = 0;
    #1 chk("rq_rst_req", req, 0);
    #2 rst_n = 1;
    edge_step();
    chk("rq_after_req", req, 0);

    // Write enable qualification
    ex_valid = 1; ex_regwrite = 1; ex_rd = 5; ex_sel = 2'b01; ex_alu = 32'h9;
    edge_step();
    chk("q_rd5", wb_regwrite, 1);
    ex_rd = 0;
    edge_step();
    chk("q_rd0", wb_regwrite, 0);
    ex_rd = 5;
    edge_step();
    chk("q_rd5_again", wb_regwrite, 1);
    ex_valid = 0;
    edge_step();
    chk("q_invalid", wb_regwrite, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
